decimal_countdown_timer: RTL and testbench

DECIMAL_COUNTDOWN_TIMER -- requirements
Module: decimal_countdown_timer

---
 rtl/decimal_countdown_timer.sv | 118 +++++++++++
 tb/tb_decimal_countdown_timer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decimal_countdown_timer.sv
// Two-digit BCD countdown timer with load, start/resume and pause.
// A prescaler divides the clock into decrement ticks; all outputs are registered.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | count loaded or reset, waiting for start
// RUN     | prescaler advancing, digits decrement on each tick
// PAUSED  | prescaler and digits frozen, start resumes
// EXPIRED | count reached 00, held until load or reset
module decimal_countdown_timer #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done,
  output logic       time_up
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic          count_zero;

  assign tick       = (state == RUN) && (prescaler == PRE_LAST);
  assign count_zero = (tens == 4'd0) && (ones == 4'd0);

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prescaler <= '0;
      tens      <= 4'd0;
      ones      <= 4'd0;
      running   <= 1'b0;
      done      <= 1'b0;
      time_up   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state     <= IDLE;
        prescaler <= '0;
        tens      <= clamp_digit(load_tens);
        ones      <= clamp_digit(load_ones);
        running   <= 1'b0;
        time_up   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !count_zero) begin
              state     <= RUN;
              prescaler <= '0;
              running   <= 1'b1;
            end
          end
          RUN: begin
            // Pause wins over a coincident tick so the frozen count is exact.
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (tick) begin
              prescaler <= '0;
              if (ones != 4'd0) begin
                ones <= ones - 4'd1;
                if (tens == 4'd0 && ones == 4'd1) begin
                  state   <= EXPIRED;
                  running <= 1'b0;
                  done    <= 1'b1;
                  time_up <= 1'b1;
                end
              end else if (tens != 4'd0) begin
                ones <= 4'd9;
                tens <= tens - 4'd1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
          PAUSED: begin
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          EXPIRED: begin
            state <= EXPIRED;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            time_up <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decimal_countdown_timer.sv
// Directed bench for decimal_countdown_timer with TICK_DIV=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_decimal_countdown_timer;

  logic       clock;
  logic       reset;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       start;
  logic       pause;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       done;
  logic       time_up;

  int checks = 0;
  int errors = 0;

  decimal_countdown_timer #(.TICK_DIV(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_tens (load_tens),
    .load_ones (load_ones),
    .start     (start),
    .pause     (pause),
    .tens      (tens),
    .ones      (ones),
    .running   (running),
    .done      (done),
    .time_up   (time_up)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; load_tens = t; load_ones = o;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
    start = 1'b0; pause = 1'b0;
    step(); step();
    checks++;
    if ({tens, ones, running, done, time_up} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state got %b expected 0", {tens, ones, running, done, time_up});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_clamp();
    do_load(4'hC, 4'hF);
    checks++;
    if ({tens, ones} !== 8'h99) begin
      errors++;
      $display("FAIL clamp_digits got %h expected 99", {tens, ones});
    end
    checks++;
    if ({running, time_up, done} !== 3'b000) begin
      errors++;
      $display("FAIL clamp_idle flags got %b expected 000", {running, time_up, done});
    end
  endtask

  task automatic test_full_countdown();
    int dones;
    do_load(4'd1, 4'd2);
    do_start();
    checks++;
    if (running !== 1'b1 || {tens, ones} !== 8'h12) begin
      errors++;
      $display("FAIL start_run got running=%b count=%h expected 1/12", running, {tens, ones});
    end
    step(); step(); step();
    checks++;
    if ({tens, ones} !== 8'h12) begin
      errors++;
      $display("FAIL before_first_tick got %h expected 12", {tens, ones});
    end
    step();
    checks++;
    if ({tens, ones} !== 8'h11) begin
      errors++;
      $display("FAIL first_tick got %h expected 11", {tens, ones});
    end
    dones = 0;
    for (int cyc = 5; cyc <= 60; cyc++) begin
      step();
      if (done === 1'b1) dones++;
      if (cyc == 47) begin
        checks++;
        if ({tens, ones, done} !== {8'h01, 1'b0}) begin
          errors++;
          $display("FAIL pre_expire got %h done=%b expected 01 done=0", {tens, ones}, done);
        end
      end
      if (cyc == 48) begin
        checks++;
        if ({tens, ones, done, time_up, running} !== {8'h00, 3'b110}) begin
          errors++;
          $display("FAIL expire got %h done=%b time_up=%b running=%b expected 00 1 1 0",
                   {tens, ones}, done, time_up, running);
        end
      end
      if (cyc == 49) begin
        checks++;
        if (done !== 1'b0 || time_up !== 1'b1) begin
          errors++;
          $display("FAIL done_one_cycle got done=%b time_up=%b expected 0 1", done, time_up);
        end
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL done_pulse_count got %0d expected 1", dones);
    end
    start = 1'b1; pause = 1'b1;
    step(); step();
    start = 1'b0; pause = 1'b0;
    checks++;
    if ({tens, ones, time_up, running, done} !== {8'h00, 3'b100}) begin
      errors++;
      $display("FAIL expired_hold got %h flags=%b expected 00 100", {tens, ones}, {time_up, running, done});
    end
  endtask

  task automatic test_borrow();
    do_load(4'd2, 4'd0);
    do_start();
    step(); step(); step(); step();
    checks++;
    if ({tens, ones} !== 8'h19) begin
      errors++;
      $display("FAIL borrow got %h expected 19", {tens, ones});
    end
  endtask

  task automatic test_pause();
    do_load(4'd0, 4'd5);
    do_start();
    step(); step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    checks++;
    if (running !== 1'b0 || {tens, ones} !== 8'h05) begin
      errors++;
      $display("FAIL pause_enter got running=%b count=%h expected 0/05", running, {tens, ones});
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if ({tens, ones} !== 8'h05) begin
      errors++;
      $display("FAIL pause_frozen got %h expected 05", {tens, ones});
    end
    do_start();
    step();
    checks++;
    if ({tens, ones, running} !== {8'h05, 1'b1}) begin
      errors++;
      $display("FAIL resume_one got %h running=%b expected 05 1", {tens, ones}, running);
    end
    step();
    checks++;
    if ({tens, ones} !== 8'h04) begin
      errors++;
      $display("FAIL resume_retained got %h expected 04", {tens, ones});
    end
    // Pause coincident with a tick must drop that decrement.
    step(); step(); step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    checks++;
    if ({tens, ones, running} !== {8'h04, 1'b0}) begin
      errors++;
      $display("FAIL pause_on_tick got %h running=%b expected 04 0", {tens, ones}, running);
    end
  endtask

  task automatic test_zero_start();
    int dones;
    do_load(4'd0, 4'd0);
    dones = 0;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1 || running === 1'b1) dones++;
    end
    start = 1'b0;
    checks++;
    if (dones !== 0 || time_up !== 1'b0) begin
      errors++;
      $display("FAIL zero_start got active_cycles=%0d time_up=%b expected 0 0", dones, time_up);
    end
  endtask

  task automatic test_load_during_run();
    do_load(4'd4, 4'd5);
    do_start();
    step(); step(); step(); step(); step();
    start = 1'b1; pause = 1'b1;
    do_load(4'd3, 4'd3);
    start = 1'b0; pause = 1'b0;
    checks++;
    if ({tens, ones, running} !== {8'h33, 1'b0}) begin
      errors++;
      $display("FAIL load_priority got %h running=%b expected 33 0", {tens, ones}, running);
    end
    step(); step(); step(); step(); step();
    checks++;
    if ({tens, ones} !== 8'h33) begin
      errors++;
      $display("FAIL load_idle_hold got %h expected 33", {tens, ones});
    end
  endtask

  task automatic test_async_reset();
    do_load(4'd1, 4'd2);
    do_start();
    step(); step(); step(); step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({tens, ones, running, done, time_up} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset got %b expected 0", {tens, ones, running, done, time_up});
    end
    step();
    reset = 1'b0;
    start = 1'b1;
    step(); step();
    start = 1'b0;
    checks++;
    if ({tens, ones, running, done, time_up} !== 11'd0) begin
      errors++;
      $display("FAIL post_reset_hold got %b expected 0", {tens, ones, running, done, time_up});
    end
    do_load(4'd0, 4'd7);
    checks++;
    if ({tens, ones} !== 8'h07) begin
      errors++;
      $display("FAIL reload_after_reset got %h expected 07", {tens, ones});
    end
  endtask

  initial begin
    test_reset();
    test_clamp();
    test_full_countdown();
    test_borrow();
    test_pause();
    test_zero_start();
    test_load_during_run();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
